// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader.
// Holds the loader FSM state type and the frame layout constants.
// Used by boot_loader and boot_word_asm through import boot_pkg::*.
package boot_pkg;

    // Header: LEN[7:0], LEN[15:8], BASE[7:0], BASE[15:8]
    localparam int unsigned HDR_BYTES  = 4;
    // Little-endian data bytes per memory word
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        StHLen0,
        StHLen1,
        StHBase0,
        StHBase1,
        StData,
        StCsum,
        StDone,
        StErr
    } boot_state_e;

endpackage

// File: rtl/boot_word_asm.sv
// Assembles a stream of bytes into little-endian 32-bit words.
// A byte-lane counter tracks the position inside the current word. Lower lanes are held
// in a shift register. When the last lane arrives, the full word is registered and
// word_valid pulses for one cycle.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   clr        in   frame start: drop any partial word, restart at lane 0
//   byte_valid in   accept byte_data this cycle
//   byte_data  in   stream byte
//   last_lane  out  the next accepted byte completes a word
//   word_valid out  one-cycle strobe, word holds the completed word
//   word       out  {byte3, byte2, byte1, byte0}
module boot_word_asm
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int unsigned LaneW = $clog2(WORD_BYTES);

    logic [LaneW-1:0] lane_q, lane_d;
    logic [23:0]      sr_q, sr_d;
    logic [31:0]      word_q, word_d;
    logic             valid_q, valid_d;

    assign last_lane  = (lane_q == LaneW'(WORD_BYTES - 1));
    assign word_valid = valid_q;
    assign word       = word_q;

    always_comb begin
        lane_d  = lane_q;
        sr_d    = sr_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clr) begin
            lane_d = '0;
            sr_d   = '0;
        end else if (byte_valid) begin
            // Newest byte enters at the top; byte0 ends up in bits [7:0]
            sr_d   = {byte_data, sr_q[23:8]};
            lane_d = lane_q + 1'b1;
            if (last_lane) begin
                valid_d = 1'b1;
                word_d  = {byte_data, sr_q};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses a LEN/BASE framed program image and writes each
// little-endian 32-bit word to instruction and data memory together. The CPU is held
// in reset until the image has fully landed.
// Optional trailing XOR checksum is compiled in with `define BOOT_LOADER_CSUM_EN;
// without it there is no CSUM state and boot_err is tied low.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   byte available on in_data
//   in_data    in   stream byte
//   in_ready   out  byte accepted when in_valid && in_ready
//   restart    in   one-cycle pulse, re-arms from DONE/ERR
//   mem_we     out  one-cycle word write strobe
//   mem_addr   out  word address of the write
//   mem_wdata  out  write word
//   cpu_rst    out  CPU reset, released one cycle after DONE
//   boot_done  out  sticky load-complete flag
//   boot_err   out  sticky checksum-mismatch flag
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              boot_done,
    output logic              boot_err
);

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              boot_done_q, boot_done_d;

    logic accept;
    logic data_acc;
    logic frame_start;
    logic last_lane;
    logic word_end;
    logic last_word;
    logic in_final;

    assign in_ready    = (state_q != StDone) && (state_q != StErr);
    assign accept      = in_valid && in_ready;
    assign data_acc    = accept && (state_q == StData);
    assign frame_start = accept && (state_q == StHBase1);
    assign word_end    = data_acc && last_lane;
    assign last_word   = ((word_idx_q + 1'b1) == len_q);
    assign in_final    = (state_q == StDone) && !restart;

    boot_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (frame_start),
        .byte_valid (data_acc),
        .byte_data  (in_data),
        .last_lane  (last_lane),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

`ifdef BOOT_LOADER_CSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       boot_err_q, boot_err_d;
    logic       csum_ok;

    assign csum_ok  = (in_data == csum_q);
    assign boot_err = boot_err_q;

    always_comb begin
        csum_d = csum_q;
        if (frame_start) begin
            csum_d = '0;
        end else if (data_acc) begin
            csum_d = csum_q ^ in_data;
        end
        boot_err_d = (state_q == StErr) && !restart;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q     <= '0;
            boot_err_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            boot_err_q <= boot_err_d;
        end
    end
`else
    assign boot_err = 1'b0;
`endif

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StHLen0:  if (accept) state_d = StHLen1;
            StHLen1:  if (accept) state_d = StHBase0;
            StHBase0: if (accept) state_d = StHBase1;
            StHBase1: begin
                if (accept) begin
                    if (len_q != '0) begin
                        state_d = StData;
                    end else begin
`ifdef BOOT_LOADER_CSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
            StData: begin
                if (word_end && last_word) begin
`ifdef BOOT_LOADER_CSUM_EN
                    state_d = StCsum;
`else
                    state_d = StDone;
`endif
                end
            end
            StCsum: begin
`ifdef BOOT_LOADER_CSUM_EN
                if (accept) state_d = csum_ok ? StDone : StErr;
`else
                state_d = StHLen0;
`endif
            end
            StDone:   if (restart) state_d = StHLen0;
            StErr:    if (restart) state_d = StHLen0;
            default:  state_d = StHLen0;
        endcase
    end

    // Header capture, word counter, write address and status outputs
    always_comb begin
        len_d      = len_q;
        base_d     = base_q;
        word_idx_d = word_idx_q;
        mem_addr_d = mem_addr_q;

        if (accept) begin
            case (state_q)
                StHLen0:  len_d  = LEN_W'(in_data);
                StHLen1:  len_d  = LEN_W'({in_data, len_q[7:0]});
                StHBase0: base_d = ADDR_W'(in_data);
                StHBase1: base_d = ADDR_W'({in_data, base_q[7:0]});
                default:  ;
            endcase
        end

        if (frame_start) begin
            word_idx_d = '0;
        end else if (word_end) begin
            word_idx_d = word_idx_q + 1'b1;
            // Address wraps naturally at ADDR_W bits
            mem_addr_d = base_q + ADDR_W'(word_idx_q);
        end

        // Registered from DONE so the final write always lands before the CPU runs
        cpu_rst_d   = !in_final;
        boot_done_d = in_final;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHLen0;
            len_q       <= '0;
            base_q      <= '0;
            word_idx_q  <= '0;
            mem_addr_q  <= '0;
            cpu_rst_q   <= 1'b1;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            base_q      <= base_d;
            word_idx_q  <= word_idx_d;
            mem_addr_q  <= mem_addr_d;
            cpu_rst_q   <= cpu_rst_d;
            boot_done_q <= boot_done_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign cpu_rst   = cpu_rst_q;
    assign boot_done = boot_done_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a byte-counting frame model predicts every
// output each cycle; literal expectations pin the model on the directed frames.
module tb_boot_loader;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 16;
`ifdef BOOT_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              restart = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              boot_done;
    logic              boot_err;

    always #5 clk = ~clk;

    boot_loader #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_status = 0;   // 0 loading, 1 done, 2 error
    int          m_age    = 0;   // edges since finishing
    int          m_nb     = 0;   // bytes consumed in the current frame
    int          m_len    = 0;
    int          m_base   = 0;
    logic [7:0]  m_xor    = 8'h00;
    logic [31:0] m_word   = 32'h0;
    logic        m_we     = 1'b0;
    logic [13:0] m_addr   = 14'h0;
    logic [31:0] m_data   = 32'h0;

    task model_finish(input int s);
        m_status = s;
        m_age    = 0;
    endtask

    task model_byte(input logic [7:0] b);
        int d;
        case (m_nb)
            0: m_len = int'(b);
            1: m_len = m_len + (int'(b) << 8);
            2: m_base = int'(b);
            3: begin
                m_base = m_base + (int'(b) << 8);
                m_xor  = 8'h00;
                if (m_len == 0 && !CSUM) model_finish(1);
            end
            default: begin
                d = m_nb - 4;
                if (d < 4 * m_len) begin
                    m_word = {b, m_word[31:8]};
                    m_xor  = m_xor ^ b;
                    if (d % 4 == 3) begin
                        m_we   = 1'b1;
                        m_addr = 14'((m_base + d / 4) % 16384);
                        m_data = m_word;
                        if (d == 4 * m_len - 1 && !CSUM) model_finish(1);
                    end
                end else begin
                    model_finish((b == m_xor) ? 1 : 2);
                end
            end
        endcase
        m_nb++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_status = 0; m_age = 0; m_nb = 0; m_len = 0; m_base = 0;
            m_xor = 8'h00; m_we = 1'b0;
        end else begin
            m_we = 1'b0;
            if (m_status == 0) begin
                if (in_valid) model_byte(in_data);
            end else if (restart) begin
                m_status = 0;
                m_nb     = 0;
            end else if (m_age < 2) begin
                m_age++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] mem_seen [0:16383];
    int          wr_count = 0;

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_status == 0);
        chk("cpu_rst", cpu_rst, !(m_status == 1 && m_age >= 1));
        chk("boot_done", boot_done, m_status == 1 && m_age >= 1);
        chk("boot_err", boot_err, m_status == 2 && m_age >= 1);
        chk("mem_we", mem_we, m_we);
        if (m_we) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_data);
        end
        if (mem_we) begin
            mem_seen[mem_addr] = mem_wdata;
            wr_count++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] fq[$];
    logic [7:0] fx;

    task automatic push_header(input int len, input int base);
        fq.push_back(8'(len));
        fq.push_back(8'(len >> 8));
        fq.push_back(8'(base));
        fq.push_back(8'(base >> 8));
        fx = 8'h00;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            fq.push_back(w[8*i +: 8]);
            fx = fx ^ w[8*i +: 8];
        end
    endtask

    task automatic push_csum(input logic [7:0] corrupt);
        if (CSUM) fq.push_back(fx ^ corrupt);
    endtask

    task automatic send_frame(input bit rand_duty);
        logic [7:0] b;
        while (fq.size() > 0) begin
            b = fq.pop_front();
            if (rand_duty) begin
                while ($urandom_range(2) != 0) begin
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = b;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic wait_finish();
        int n = 0;
        while (!(boot_done || boot_err) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("finish_reached", boot_done || boot_err, 1'b1);
    endtask

    int n0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: two-word frame at base 0, exact cpu_rst release timing
        push_header(2, 16'h0000);
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
        push_csum(8'h00);
        send_frame(1'b0);
        chk("t1_cpu_rst_hold", cpu_rst, 1);
        @(posedge clk); #1;
        chk("t1_cpu_rst_fall", cpu_rst, 0);
        chk("t1_boot_done", boot_done, 1);
        chk("t1_mem0", mem_seen[0], 32'h12345678);
        chk("t1_mem1", mem_seen[1], 32'hDEADBEEF);

`ifdef BOOT_LOADER_CSUM_EN
        // 2: bad checksum, stray bytes in ERR, then recovery
        do_restart();
        push_header(2, 16'h0000);
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
        push_csum(8'h01);
        send_frame(1'b0);
        @(posedge clk); #1;
        chk("t2_boot_err", boot_err, 1);
        chk("t2_cpu_rst", cpu_rst, 1);
        chk("t2_in_ready", in_ready, 0);
        fq.push_back(8'hAA); fq.push_back(8'h55); fq.push_back(8'h01);
        send_frame(1'b0);
        chk("t2_still_err", boot_err, 1);
        do_restart();
        chk("t2_err_clear", boot_err, 0);
        push_header(1, 16'h0010);
        push_word(32'hCAFEF00D);
        push_csum(8'h00);
        send_frame(1'b0);
        wait_finish();
        chk("t2_recover_done", boot_done, 1);
        chk("t2_recover_mem", mem_seen[16'h0010], 32'hCAFEF00D);
`endif

        // 3: address wrap at the top of the word space
        do_restart();
        push_header(1, 16'h3FFF);
        push_word($urandom);
        push_csum(8'h00);
        send_frame(1'b0);
        wait_finish();
        do_restart();
        push_header(2, 16'h3FFF);
        push_word(32'h11223344);
        push_word(32'h55667788);
        push_csum(8'h00);
        send_frame(1'b0);
        wait_finish();
        chk("t3_mem_3fff", mem_seen[14'h3FFF], 32'h11223344);
        chk("t3_mem_0000", mem_seen[0], 32'h55667788);

        // 4: empty image
        do_restart();
        n0 = wr_count;
        push_header(0, 16'h1234);
        push_csum(8'h00);
        send_frame(1'b0);
        wait_finish();
        @(posedge clk); #1;
        chk("t4_no_writes", wr_count - n0, 0);
        chk("t4_boot_done", boot_done, 1);
        chk("t4_cpu_rst", cpu_rst, 0);

        // 5: random data, sparse in_valid
        do_restart();
        n0 = wr_count;
        push_header(8, $urandom_range(16'hFFFF));
        for (int i = 0; i < 8; i++) push_word($urandom);
        push_csum(8'h00);
        send_frame(1'b1);
        wait_finish();
        chk("t5_write_count", wr_count - n0, 8);
        chk("t5_boot_done", boot_done, 1);

        // 6: reset in the middle of word 1
        do_restart();
        n0 = wr_count;
        push_header(4, 16'h0100);
        push_word(32'hA1A2A3A4);
        fq.push_back(8'h01); fq.push_back(8'h02);
        send_frame(1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_cpu_rst", cpu_rst, 1);
        chk("t6_rst_mem_we", mem_we, 0);
        chk("t6_rst_mem_addr", mem_addr, 0);
        chk("t6_rst_mem_wdata", mem_wdata, 0);
        chk("t6_rst_done", boot_done, 0);
        chk("t6_one_write", wr_count - n0, 1);
        chk("t6_word0", mem_seen[16'h0100], 32'hA1A2A3A4);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_header(4, 16'h0200);
        for (int i = 0; i < 4; i++) push_word(32'h0B0C0D00 + 32'(i));
        push_csum(8'h00);
        send_frame(1'b1);
        wait_finish();
        chk("t6_reload_done", boot_done, 1);
        chk("t6_reload_count", wr_count - n0, 5);
        chk("t6_reload_word3", mem_seen[16'h0203], 32'h0B0C0D03);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case stimulus itself stalls
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
